// File: rtl/inst_sram_axi_bridge_if.sv
// rtl/inst_sram_axi_bridge_if.sv - fetch-side SRAM-like port plus AXI4 AR/R channels seen by the bridge
// master = fetch stage and AXI slave side; slave = the bridge itself.
interface inst_sram_axi_bridge_if;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport slave (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/inst_sram_axi_bridge.sv
// rtl/inst_sram_axi_bridge.sv - instruction SRAM-like to single-beat AXI4 read bridge
// Optional sticky R-error flag inst_bus_err under INST_BRIDGE_RESP_CHK_EN.
module inst_sram_axi_bridge #(
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [3:0] ARID_VAL        = 4'd0
) (
  input  logic                  clk,
  input  logic                  resetn,
  inst_sram_axi_bridge_if.slave bus
`ifdef INST_BRIDGE_RESP_CHK_EN
  ,
  output logic                  inst_bus_err
`endif
);
  localparam int            CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  typedef enum logic {AR_IDLE, AR_PEND} ar_state_t;

  ar_state_t     state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   araddr_q;
  logic [1:0]    size_q;
  logic          accept;
  logic          r_hs;
  logic          unused_inputs;

  // Gated by resetn so no request is acknowledged while reset is held.
  assign accept = resetn & bus.inst_sram_req & ~bus.inst_sram_wr &
                  (state == AR_IDLE) & (cnt < CNT_MAX);
  assign r_hs   = bus.rvalid & bus.rready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= AR_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      AR_IDLE: if (accept)      state_nxt = AR_PEND;
      AR_PEND: if (bus.arready) state_nxt = AR_IDLE;
      default:                  state_nxt = AR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      araddr_q <= 32'd0;
      size_q   <= 2'd0;
    end else if (accept) begin
      araddr_q <= bus.inst_sram_addr;
      size_q   <= bus.inst_sram_size;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else begin
      case ({accept, r_hs})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.inst_sram_addr_ok = accept;
  assign bus.inst_sram_data_ok = r_hs & bus.rlast;
  assign bus.inst_sram_rdata   = bus.rdata;

  assign bus.arid    = ARID_VAL;
  assign bus.araddr  = araddr_q;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = {1'b0, size_q};
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'd0;
  assign bus.arprot  = 3'd0;
  assign bus.arvalid = (state == AR_PEND);
  assign bus.rready  = (cnt != '0);

`ifdef INST_BRIDGE_RESP_CHK_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                   inst_bus_err <= 1'b0;
    else if (r_hs && bus.rresp[1]) inst_bus_err <= 1'b1;
  end

  assign unused_inputs = ^{bus.inst_sram_wstrb, bus.inst_sram_wdata, bus.rid, bus.rresp[0]};
`else
  assign unused_inputs = ^{bus.inst_sram_wstrb, bus.inst_sram_wdata, bus.rid, bus.rresp};
`endif
endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// tb/tb_inst_sram_axi_bridge.sv - directed self-checking bench for inst_sram_axi_bridge
// Covers INST_BRIDGE_RESP_CHK_EN defined and undefined.
module tb_inst_sram_axi_bridge;
  logic clk = 1'b0;
  logic resetn;
  int   n_checks = 0;
  int   n_fails  = 0;

  inst_sram_axi_bridge_if bus ();
`ifdef INST_BRIDGE_RESP_CHK_EN
  logic inst_bus_err;
`endif

  always #5 clk = ~clk;

  inst_sram_axi_bridge #(
    .MAX_OUTSTANDING(2),
    .ARID_VAL       (4'd0)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
`ifdef INST_BRIDGE_RESP_CHK_EN
    ,
    .inst_bus_err(inst_bus_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_req(input logic r, input logic [31:0] a, input logic [1:0] sz);
    bus.inst_sram_req  = r;
    bus.inst_sram_wr   = 1'b0;
    bus.inst_sram_addr = a;
    bus.inst_sram_size = sz;
  endtask

  task automatic drive_r(input logic v, input logic [31:0] d, input logic [1:0] resp);
    bus.rvalid = v;
    bus.rlast  = v;
    bus.rdata  = d;
    bus.rresp  = resp;
  endtask

  // Slave-side protocol rules: single-beat bursts only, never a beat with nothing outstanding.
  always @(negedge clk) begin
    if (resetn === 1'b1 && bus.rvalid === 1'b1) begin
      check("rlast_with_rvalid", {31'd0, bus.rlast}, 32'd1);
      check("rvalid_needs_outstanding", {31'd0, dut.cnt != '0}, 32'd1);
    end
  end

  initial begin
    resetn              = 1'b0;
    bus.inst_sram_wstrb = 4'hf;
    bus.inst_sram_wdata = 32'h0;
    bus.arready         = 1'b0;
    bus.rid             = 4'd0;
    drive_req(1'b0, 32'h0, 2'b00);
    drive_r(1'b0, 32'h0, 2'b00);
    tick();
    tick();

    #1;
    check("rst_arvalid", {31'd0, bus.arvalid}, 32'd0);
    check("rst_araddr", bus.araddr, 32'h0);
    check("rst_arsize", {29'd0, bus.arsize}, 32'd0);
    check("rst_rready", {31'd0, bus.rready}, 32'd0);
    check("rst_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd0);
    check("rst_data_ok", {31'd0, bus.inst_sram_data_ok}, 32'd0);
    check("rst_cnt", {30'd0, dut.cnt}, 32'd0);
    check("const_arlen", {24'd0, bus.arlen}, 32'd0);
    check("const_arburst", {30'd0, bus.arburst}, 32'd1);
    check("const_arid", {28'd0, bus.arid}, 32'd0);
`ifdef INST_BRIDGE_RESP_CHK_EN
    check("rst_bus_err", {31'd0, inst_bus_err}, 32'd0);
`endif
    resetn = 1'b1;
    tick();

    // single fetch, minimum latency
    bus.arready = 1'b1;
    drive_req(1'b1, 32'h1c000000, 2'b10);
    #1;
    check("t1_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
    check("t1_arvalid_T", {31'd0, bus.arvalid}, 32'd0);
    tick();
    drive_req(1'b0, 32'h0, 2'b00);
    #1;
    check("t1_arvalid", {31'd0, bus.arvalid}, 32'd1);
    check("t1_araddr", bus.araddr, 32'h1c000000);
    check("t1_arsize", {29'd0, bus.arsize}, 32'd2);
    check("t1_rready", {31'd0, bus.rready}, 32'd1);
    check("t1_data_ok_early", {31'd0, bus.inst_sram_data_ok}, 32'd0);
    tick();
    drive_r(1'b1, 32'h02800c0c, 2'b00);
    #1;
    check("t1_data_ok", {31'd0, bus.inst_sram_data_ok}, 32'd1);
    check("t1_rdata", bus.inst_sram_rdata, 32'h02800c0c);
    check("t1_arvalid_clr", {31'd0, bus.arvalid}, 32'd0);
    tick();
    drive_r(1'b0, 32'h0, 2'b00);
    #1;
    check("t1_rready_idle", {31'd0, bus.rready}, 32'd0);

    // AR stall
    bus.arready = 1'b0;
    drive_req(1'b1, 32'h1c000004, 2'b10);
    #1;
    check("t2_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
    tick();
    drive_req(1'b1, 32'h1c000008, 2'b10);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t2_stall_arvalid", {31'd0, bus.arvalid}, 32'd1);
      check("t2_stall_araddr", bus.araddr, 32'h1c000004);
      check("t2_stall_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd0);
      tick();
    end
    bus.arready = 1'b1;
    #1;
    check("t2_hs_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd0);
    tick();
    #1;
    check("t2_after_hs_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
    check("t2_after_hs_arvalid", {31'd0, bus.arvalid}, 32'd0);
    tick();
    drive_req(1'b0, 32'h0, 2'b00);
    #1;
    check("t2_ar2_araddr", bus.araddr, 32'h1c000008);
    check("t2_cnt2", {30'd0, dut.cnt}, 32'd2);
    tick();
    drive_r(1'b1, 32'h00000004, 2'b00);
    #1;
    check("t2_r0_data_ok", {31'd0, bus.inst_sram_data_ok}, 32'd1);
    tick();
    drive_r(1'b1, 32'h00000008, 2'b00);
    #1;
    check("t2_r1_rdata", bus.inst_sram_rdata, 32'h00000008);
    tick();
    drive_r(1'b0, 32'h0, 2'b00);
    #1;
    check("t2_cnt0", {30'd0, dut.cnt}, 32'd0);

    // outstanding limit of 2
    drive_req(1'b1, 32'h1c000000, 2'b10);
    #1;
    check("t3_acc0", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
    tick();
    drive_req(1'b1, 32'h1c000004, 2'b10);
    #1;
    check("t3_block_arvalid", {31'd0, bus.inst_sram_addr_ok}, 32'd0);
    tick();
    #1;
    check("t3_acc1", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
    tick();
    drive_req(1'b1, 32'h1c000008, 2'b10);
    #1;
    check("t3_third_blocked_ar", {31'd0, bus.inst_sram_addr_ok}, 32'd0);
    tick();
    #1;
    check("t3_third_blocked_cnt", {31'd0, bus.inst_sram_addr_ok}, 32'd0);
    check("t3_cnt_full", {30'd0, dut.cnt}, 32'd2);
    check("t3_arvalid_idle", {31'd0, bus.arvalid}, 32'd0);
    tick();
    drive_r(1'b1, 32'ha0a00000, 2'b00);
    #1;
    check("t3_r0_data_ok", {31'd0, bus.inst_sram_data_ok}, 32'd1);
    check("t3_r0_rdata", bus.inst_sram_rdata, 32'ha0a00000);
    check("t3_r0_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd0);
    tick();
    drive_r(1'b0, 32'h0, 2'b00);
    #1;
    check("t3_third_acc", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
    tick();
    drive_req(1'b0, 32'h0, 2'b00);
    drive_r(1'b1, 32'ha0a00004, 2'b00);
    #1;
    check("t3_cnt_refill", {30'd0, dut.cnt}, 32'd2);
    check("t3_ar3_araddr", bus.araddr, 32'h1c000008);
    check("t3_r1_rdata", bus.inst_sram_rdata, 32'ha0a00004);
    check("t3_r1_data_ok", {31'd0, bus.inst_sram_data_ok}, 32'd1);
    tick();
    drive_req(1'b1, 32'h1c00000c, 2'b10);
    drive_r(1'b1, 32'ha0a00008, 2'b00);
    #1;
    check("t3_same_cycle_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
    check("t3_same_cycle_data_ok", {31'd0, bus.inst_sram_data_ok}, 32'd1);
    tick();
    drive_req(1'b0, 32'h0, 2'b00);
    drive_r(1'b0, 32'h0, 2'b00);
    #1;
    check("t3_cnt_unchanged", {30'd0, dut.cnt}, 32'd1);
    check("t3_ar4_araddr", bus.araddr, 32'h1c00000c);
    tick();
    drive_r(1'b1, 32'ha0a0000c, 2'b00);
    #1;
    check("t3_r3_rdata", bus.inst_sram_rdata, 32'ha0a0000c);
    tick();
    drive_r(1'b0, 32'h0, 2'b00);
    #1;
    check("t3_cnt_drained", {30'd0, dut.cnt}, 32'd0);

    // write requests are never accepted
    drive_req(1'b1, 32'h1c000020, 2'b10);
    bus.inst_sram_wr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t4_wr_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd0);
      check("t4_wr_arvalid", {31'd0, bus.arvalid}, 32'd0);
      tick();
    end
    drive_req(1'b0, 32'h0, 2'b00);

    // error response, half-word size
    drive_req(1'b1, 32'h1c000030, 2'b01);
    #1;
    check("t5_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
    tick();
    drive_req(1'b0, 32'h0, 2'b00);
    #1;
    check("t5_arsize", {29'd0, bus.arsize}, 32'd1);
    tick();
    drive_r(1'b1, 32'hdead0001, 2'b10);
    #1;
    check("t5_err_data_ok", {31'd0, bus.inst_sram_data_ok}, 32'd1);
    check("t5_err_rdata", bus.inst_sram_rdata, 32'hdead0001);
`ifdef INST_BRIDGE_RESP_CHK_EN
    check("t5_err_not_yet", {31'd0, inst_bus_err}, 32'd0);
`endif
    tick();
    drive_r(1'b0, 32'h0, 2'b00);
    #1;
`ifdef INST_BRIDGE_RESP_CHK_EN
    check("t5_err_set", {31'd0, inst_bus_err}, 32'd1);
`endif
    drive_req(1'b1, 32'h1c000034, 2'b10);
    tick();
    drive_req(1'b0, 32'h0, 2'b00);
    tick();
    drive_r(1'b1, 32'h00000013, 2'b00);
    #1;
    check("t5_ok_data_ok", {31'd0, bus.inst_sram_data_ok}, 32'd1);
    tick();
    drive_r(1'b0, 32'h0, 2'b00);
    #1;
`ifdef INST_BRIDGE_RESP_CHK_EN
    check("t5_err_sticky", {31'd0, inst_bus_err}, 32'd1);
`endif

    // asynchronous reset mid-cycle with an AR pending and one read outstanding
    bus.arready = 1'b0;
    drive_req(1'b1, 32'h1c000040, 2'b10);
    #1;
    check("t6_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
    tick();
    #1;
    check("t6_pre_arvalid", {31'd0, bus.arvalid}, 32'd1);
    check("t6_pre_cnt", {30'd0, dut.cnt}, 32'd1);
    resetn = 1'b0;
    drive_r(1'b1, 32'h12345678, 2'b00);
    #1;
    check("t6_arvalid", {31'd0, bus.arvalid}, 32'd0);
    check("t6_rready", {31'd0, bus.rready}, 32'd0);
    check("t6_addr_ok_rst", {31'd0, bus.inst_sram_addr_ok}, 32'd0);
    check("t6_data_ok", {31'd0, bus.inst_sram_data_ok}, 32'd0);
    check("t6_cnt", {30'd0, dut.cnt}, 32'd0);
    check("t6_araddr", bus.araddr, 32'h0);
`ifdef INST_BRIDGE_RESP_CHK_EN
    check("t6_bus_err", {31'd0, inst_bus_err}, 32'd0);
`endif
    tick();
    drive_r(1'b0, 32'h0, 2'b00);
    drive_req(1'b0, 32'h0, 2'b00);
    resetn = 1'b1;
    tick();
    #1;
    check("t6_post_rready", {31'd0, bus.rready}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
